// File: rtl/klein_dec_control.sv
// Sequencer for the serial KLEIN-96 decryption datapath: a key-forward phase
// (round index counting up), then the decryption rounds counting down, then a one-cycle ready.
module klein_dec_control #(
  parameter int NR = 20
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       keyfwd,
  output logic [4:0] round,
  output logic       rfirst,
  output logic       rlast,
  output logic       ready,
  output logic [0:3] sels,
  output logic [0:4] selk
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEYFWD,
    S_DEC,
    S_DONE
  } state_e;

  localparam logic [4:0] ROUND_FWD_LAST = 5'(NR - 1);
  localparam logic [4:0] ROUND_DEC_FIRST = 5'(NR);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] round_q, round_d;

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      round_q <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = 3'd0;
    round_d = round_q;
    if (start) begin
      state_d = S_KEYFWD;
      round_d = 5'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          round_d = 5'd0;
        end
        S_KEYFWD: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (round_q == ROUND_FWD_LAST) begin
              state_d = S_DEC;
              round_d = ROUND_DEC_FIRST;
            end else begin
              round_d = round_q + 5'd1;
            end
          end
        end
        S_DEC: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (round_q == 5'd1) begin
              state_d = S_DONE;
              round_d = 5'd0;
            end else begin
              round_d = round_q - 5'd1;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          round_d = 5'd0;
        end
        default: begin
          state_d = S_IDLE;
          round_d = 5'd0;
        end
      endcase
    end
  end

  // Per-cycle datapath selects within one 8-cycle round; the key path uses the
  // same schedule in both phases, the state path only while decrypting.
  logic [0:3] sels_round;
  logic [0:4] selk_round;

  always_comb begin
    sels_round = 4'b0000;
    selk_round = 5'b00000;
    unique case (cnt_q)
      3'd0: begin sels_round = 4'b0000; selk_round = 5'b01110; end
      3'd1: begin sels_round = 4'b0001; selk_round = 5'b01110; end
      3'd2: begin sels_round = 4'b0011; selk_round = 5'b10100; end
      3'd3: begin sels_round = 4'b0111; selk_round = 5'b01100; end
      3'd4: begin sels_round = 4'b0000; selk_round = 5'b01010; end
      3'd5: begin sels_round = 4'b1001; selk_round = 5'b01011; end
      3'd6: begin sels_round = 4'b1011; selk_round = 5'b01010; end
      3'd7: begin sels_round = 4'b0111; selk_round = 5'b00000; end
      default: begin sels_round = 4'b0000; selk_round = 5'b00000; end
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    keyfwd = 1'b0;
    rfirst = 1'b0;
    rlast  = 1'b0;
    ready  = 1'b0;
    sels   = 4'b0000;
    selk   = 5'b00000;
    round  = round_q;
    unique case (state_q)
      S_KEYFWD: begin
        busy   = 1'b1;
        keyfwd = 1'b1;
        selk   = selk_round;
      end
      S_DEC: begin
        busy   = 1'b1;
        rfirst = (round_q == ROUND_DEC_FIRST);
        rlast  = (round_q == 5'd1);
        sels   = sels_round;
        selk   = selk_round;
      end
      S_DONE: begin
        ready = 1'b1;
        round = 5'd0;
      end
      default: begin
        round = 5'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_klein_dec_control.sv
// Directed bench for klein_dec_control at NR=20: idle after reset, a full run,
// restart mid-decrypt, asynchronous reset mid-decrypt and a held start.
module tb_klein_dec_control;

  localparam int NR = 20;
  localparam int PHASE = NR * 8;

  logic       ck;
  logic       rst;
  logic       start;
  logic       busy;
  logic       keyfwd;
  logic [4:0] round;
  logic       rfirst;
  logic       rlast;
  logic       ready;
  logic [0:3] sels;
  logic [0:4] selk;

  int n_vec;
  int n_err;

  logic [3:0] sels_tab [8];
  logic [4:0] selk_tab [8];

  klein_dec_control #(.NR(NR)) dut (
    .ck     (ck),
    .rst    (rst),
    .start  (start),
    .busy   (busy),
    .keyfwd (keyfwd),
    .round  (round),
    .rfirst (rfirst),
    .rlast  (rlast),
    .ready  (ready),
    .sels   (sels),
    .selk   (selk)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and land on the following falling edge for sampling.
  task automatic step();
    @(posedge ck);
    @(negedge ck);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},   32'(busy),   32'd0);
    check({tag, ".keyfwd"}, 32'(keyfwd), 32'd0);
    check({tag, ".round"},  32'(round),  32'd0);
    check({tag, ".rfirst"}, 32'(rfirst), 32'd0);
    check({tag, ".rlast"},  32'(rlast),  32'd0);
    check({tag, ".ready"},  32'(ready),  32'd0);
    check({tag, ".sels"},   32'(sels),   32'd0);
    check({tag, ".selk"},   32'(selk),   32'd0);
  endtask

  // k = rising edges since the edge that sampled start (k=0 is just after it).
  task automatic check_run(input string tag, input int k);
    int e_busy, e_kf, e_round, e_rf, e_rl, e_rdy, e_sels, e_selk, c;
    e_busy = 0; e_kf = 0; e_round = 0; e_rf = 0; e_rl = 0; e_rdy = 0;
    e_sels = 0; e_selk = 0;
    if (k < PHASE) begin
      c = k % 8;
      e_busy = 1; e_kf = 1; e_round = k / 8;
      e_selk = int'(selk_tab[c]);
    end else if (k < 2 * PHASE) begin
      c = (k - PHASE) % 8;
      e_busy = 1;
      e_round = NR - (k - PHASE) / 8;
      e_rf = (e_round == NR) ? 1 : 0;
      e_rl = (e_round == 1) ? 1 : 0;
      e_sels = int'(sels_tab[c]);
      e_selk = int'(selk_tab[c]);
    end else if (k == 2 * PHASE) begin
      e_rdy = 1;
    end
    check({tag, ".busy"},   32'(busy),   32'(e_busy));
    check({tag, ".keyfwd"}, 32'(keyfwd), 32'(e_kf));
    check({tag, ".round"},  32'(round),  32'(e_round));
    check({tag, ".rfirst"}, 32'(rfirst), 32'(e_rf));
    check({tag, ".rlast"},  32'(rlast),  32'(e_rl));
    check({tag, ".ready"},  32'(ready),  32'(e_rdy));
    check({tag, ".sels"},   32'(sels),   32'(e_sels));
    check({tag, ".selk"},   32'(selk),   32'(e_selk));
  endtask

  // Called on a falling edge; returns just after the sampling edge E0.
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    sels_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b0000, 4'b1001, 4'b1011, 4'b0111};
    selk_tab = '{5'b01110, 5'b01110, 5'b10100, 5'b01100, 5'b01010, 5'b01011, 5'b01010, 5'b00000};
    rst   = 1'b1;
    start = 1'b0;
    #12;
    check_idle("reset");
    rst = 1'b0;
    @(negedge ck);

    // Idle with no start for 50 cycles.
    for (int i = 0; i < 50; i++) begin
      check_idle("idle");
      step();
    end

    // Full run: keyfwd, decrypt, ready, back to idle.
    pulse_start();
    for (int k = 0; k <= 2 * PHASE + 3; k++) begin
      check_run("run", k);
      step();
    end

    // Restart mid-decrypt at E200; ready only at the restarted run's end.
    pulse_start();
    for (int k = 0; k < 200; k++) begin
      check_run("pre_abort", k);
      step();
    end
    start = 1'b1;
    @(posedge ck);
    @(negedge ck);
    start = 1'b0;
    for (int k = 0; k <= 2 * PHASE + 2; k++) begin
      check_run("restart", k);
      step();
    end

    // Asynchronous reset between edges while decrypting.
    pulse_start();
    for (int k = 0; k < 200; k++) step();
    check_run("pre_rst", 200);
    #2 rst = 1'b1;
    #1 check_idle("async_rst");
    @(posedge ck);
    #1 check_idle("rst_hold");
    @(negedge ck);
    rst = 1'b0;
    step();
    check_idle("after_rst");

    // start held high for 30 cycles: pinned at the first keyfwd cycle.
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      check_run("held", 0);
    end
    start = 1'b0;
    for (int k = 1; k < 12; k++) begin
      step();
      check_run("held_release", k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
